// File: rtl/mux_arbiter.sv
// Four-requester round-robin arbiter with burst limiting, driving a registered
// 4:1 data mux. Grant rotates on owner release or on burst exhaustion under contention.
module mux_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;

    logic [WIDTH-1:0] din_sel;
    logic             xfer, others, last_beat;
    logic [3:0]       cnt_inc;
    logic [1:0]       base, pick;

    // First set bit of r searching base, base+1, base+2, base+3 (mod 4).
    function automatic logic [1:0] first_from(input logic [3:0] r, input logic [1:0] base_i);
        logic [1:0] idx;
        first_from = base_i;
        for (int k = 3; k >= 0; k--) begin
            idx = base_i + 2'(k);
            if (r[idx]) first_from = idx;
        end
    endfunction

    always_comb begin
        case (sel_q)
            2'd0:    din_sel = din0;
            2'd1:    din_sel = din1;
            2'd2:    din_sel = din2;
            default: din_sel = din3;
        endcase
    end

    assign xfer      = (state_q == GRANT) && req[sel_q];
    assign others    = |(req & ~gnt_q);
    assign cnt_inc   = cnt_q + 4'd1;
    assign last_beat = xfer && (cnt_inc == 4'(MAX_BURST));
    // In GRANT a search only happens on rotation, which always restarts after the owner.
    assign base      = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
    assign pick      = first_from(req, base);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (|req) state_d = GRANT;
        end else begin
            if (!req[sel_q] && !others) state_d = IDLE;
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        gnt_d  = gnt_q;
        sel_d  = sel_q;
        dout_d = dout_q;
        dv_d   = 1'b0;
        if (state_q == IDLE) begin
            if (|req) begin
                gnt_d = 4'b0001 << pick;
                sel_d = pick;
                cnt_d = '0;
            end
        end else if (xfer) begin
            dout_d = din_sel;
            dv_d   = 1'b1;
            cnt_d  = last_beat ? 4'd0 : cnt_inc;
            if (last_beat && others) begin
                ptr_d = base;
                gnt_d = 4'b0001 << pick;
                sel_d = pick;
            end
        end else begin
            ptr_d = base;
            cnt_d = '0;
            if (others) begin
                gnt_d = 4'b0001 << pick;
                sel_d = pick;
            end else begin
                gnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            gnt_q  <= '0;
            sel_q  <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            gnt_q  <= gnt_d;
            sel_q  <= sel_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
        end
    end

    always_comb begin
        gnt        = gnt_q;
        sel        = sel_q;
        dout       = dout_q;
        dout_valid = dv_q;
        busy       = (state_q == GRANT);
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: a per-cycle behavioural model plus literal
// expectations for single requester, wrap, uncontended burst, early release and async reset.
module tb_mux_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] din_a [4];
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [31:0] dout;
    logic        dout_valid;
    logic        busy;

    int checks = 0;
    int failures = 0;

    mux_arbiter #(.WIDTH(32), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din_a[0]), .din1(din_a[1]), .din2(din_a[2]), .din3(din_a[3]),
        .gnt(gnt), .sel(sel), .dout(dout), .dout_valid(dout_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: owner index, busy flag, rotation pointer, beat count.
    int          m_busy = 0, m_sel = 0, m_ptr = 0, m_cnt = 0, m_dv = 0;
    logic [31:0] m_dout = '0;
    int          xlog[$];

    function automatic int search(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    function automatic bit has_other(input logic [3:0] r, input int s);
        logic [3:0] m;
        m = 4'b0001 << s;
        return (r & ~m) != 4'b0000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_sel <= 0; m_ptr <= 0; m_cnt <= 0; m_dv <= 0; m_dout <= '0;
        end else begin
            m_dv <= 0;
            if (m_busy == 0) begin
                if (req != 4'b0000) begin
                    m_busy <= 1;
                    m_sel  <= search(req, m_ptr);
                    m_cnt  <= 0;
                end
            end else if (req[m_sel]) begin
                m_dout <= din_a[m_sel];
                m_dv   <= 1;
                xlog.push_back(m_sel);
                if (m_cnt + 1 == MB) begin
                    m_cnt <= 0;
                    if (has_other(req, m_sel)) begin
                        m_ptr <= (m_sel + 1) % 4;
                        m_sel <= search(req, (m_sel + 1) % 4);
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                m_ptr <= (m_sel + 1) % 4;
                m_cnt <= 0;
                if (req != 4'b0000) m_sel <= search(req, (m_sel + 1) % 4);
                else m_busy <= 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] eg;
        eg = (m_busy != 0) ? (4'b0001 << m_sel) : 4'b0000;
        chk("model_gnt", 32'(gnt), 32'(eg));
        chk("model_sel", 32'(sel), 32'(m_sel));
        chk("model_busy", 32'(busy), 32'(m_busy));
        chk("model_dv", 32'(dout_valid), 32'(m_dv));
        chk("model_dout", dout, m_dout);
    end

    initial begin
        int pulses;
        bit gnt_ok;
        for (int i = 0; i < 4; i++) din_a[i] = '0;

        // Reset state, asserted with no clock edge yet
        #3;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_dout", dout, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst_busy", 32'(busy), 32'h0);
        chk("idle_after_rst_gnt", 32'(gnt), 32'h0);

        // Single requester 2, three transfers, then release
        req = 4'b0100; din_a[2] = 32'hFFFF0000;
        @(negedge clk);
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_sel", 32'(sel), 32'h2);
        chk("single_dv_grant_edge", 32'(dout_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("single_dv", 32'(dout_valid), 32'h1);
            chk("single_dout", dout, 32'hFFFF0000);
        end
        req = 4'b0000;
        @(negedge clk);
        chk("single_release_busy", 32'(busy), 32'h0);
        chk("single_release_gnt", 32'(gnt), 32'h0);
        chk("single_release_sel_hold", 32'(sel), 32'h2);

        // Wrap: pointer now 3, so requester 3 wins over 0
        req = 4'b1001;
        @(negedge clk);
        chk("wrap_first", 32'(gnt), 32'h8);
        req = 4'b0001;
        @(negedge clk);
        chk("wrap_second", 32'(gnt), 32'h1);
        req = 4'b0000;
        @(negedge clk);
        chk("wrap_idle", 32'(busy), 32'h0);

        // Uncontended burst of 10 transfers by requester 1
        req = 4'b0010;
        @(negedge clk);
        chk("burst_gnt", 32'(gnt), 32'h2);
        pulses = 0; gnt_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din_a[1] = 32'hC0DE0000 + 32'(i);
            @(negedge clk);
            if (dout_valid) pulses++;
            if (gnt != 4'b0010) gnt_ok = 1'b0;
        end
        chk("burst_pulses", 32'(pulses), 32'd10);
        chk("burst_gnt_stable", 32'(gnt_ok), 32'h1);
        chk("burst_last_dout", dout, 32'hC0DE0009);

        // Early release: owner 1 drops after 2 transfers while 3 waits
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        chk("early_owner", 32'(gnt), 32'h2);
        req = 4'b1010;
        repeat (2) @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        chk("early_switch_gnt", 32'(gnt), 32'h8);
        chk("early_switch_dv", 32'(dout_valid), 32'h0);
        req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("early_new_owner_holds", 32'(gnt), 32'h8);
        end
        @(negedge clk);
        chk("early_full_burst_rotate", 32'(gnt), 32'h1);

        // Async reset mid-burst
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_dout", dout, 32'h0);
        chk("async_dv", 32'(dout_valid), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        @(negedge clk);
        din_a[0] = 32'hFFFFFFFF; din_a[1] = 32'h00000000;
        din_a[2] = 32'hFFFF0000; din_a[3] = 32'h0000FFFF;
        xlog.delete();
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        chk("post_rst_first_gnt", 32'(gnt), 32'h1);
        chk("post_rst_dout_clean", dout, 32'h0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dout_valid) pulses++;
        end
        chk("all_req_no_gap", 32'(pulses), 32'd20);
        chk("all_req_log_len", 32'(xlog.size() >= 20), 32'h1);
        if (xlog.size() >= 20)
            for (int i = 0; i < 20; i++)
                chk("all_req_order", 32'(xlog[i]), 32'((i / 4) % 4));
        req = 4'b0000;
        repeat (3) @(negedge clk);
        chk("final_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of each requester input and of dout.
REQ-002 Parameter MAX_BURST, default 4, maximum consecutive transfers per grant while another requester waits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  request per requester; bit i = requester i.
REQ-006 din0..din3  input  WIDTH each  requester data, sampled only for the granted requester.
REQ-007 gnt  output  4  one-hot grant; all-zero when idle.
REQ-008 sel  output  2  binary index of current/last owner; drives the shared 4:1 mux select.
REQ-009 dout  output  WIDTH  registered mux output.
REQ-010 dout_valid  output  1  dout holds a new transfer this cycle.
REQ-011 busy  output  1  high while in GRANT state.

Function
REQ-012 The block SHALL have states IDLE and GRANT, an internal 2-bit rotation pointer ptr, and a burst counter cnt.
REQ-013 Transfer SHALL be defined as a cycle with gnt[i]=1 and req[i]=1.
REQ-014 IDLE: if req!=0 at an edge, the block SHALL choose the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4), set gnt one-hot, sel=index, cnt=0, enter GRANT; no transfer occurs on that edge.
REQ-015 GRANT, transfer cycle: dout SHALL load din[sel] and dout_valid SHALL be 1 in the following cycle (latency 1 from transfer edge); cnt SHALL increment.
REQ-016 dout_valid SHALL be 0 in any cycle following a non-transfer cycle; dout SHALL hold its last value.
REQ-017 GRANT, owner req low: no transfer; ptr SHALL become owner+1 mod 4; if any other req bit is set, the grant SHALL move on the same edge to the first set bit searching from the new ptr, cnt=0, state stays GRANT; otherwise gnt=0 and state SHALL return to IDLE.
REQ-018 GRANT, transfer that brings cnt to MAX_BURST while any other req bit is set: the transfer SHALL complete, and on that same edge the grant SHALL rotate as in REQ-017 (ptr=owner+1), cnt=0.
REQ-019 Transfer reaching MAX_BURST with no other request pending: owner SHALL keep grant and cnt SHALL reset to 0.
REQ-020 ptr and rotation search SHALL wrap 3 -> 0.
REQ-021 gnt SHALL never have more than one bit set; sel SHALL equal the index of the set gnt bit whenever gnt!=0 and hold its value when gnt=0.
REQ-022 busy SHALL be 1 exactly when state is GRANT.
REQ-023 Requests arriving for non-owners during GRANT SHALL not affect gnt until a rotation event per REQ-017/REQ-018.

Reset
REQ-024 rst_n low SHALL immediately (without clock) force gnt=0, sel=0, dout=0, dout_valid=0, busy=0, ptr=0, cnt=0, state IDLE.
REQ-025 Reset asserted mid-burst SHALL abort the burst; after release the first grant SHALL start from ptr=0 and the aborted transfer SHALL not appear on dout.
REQ-026 Outputs SHALL be stable at reset values from rst_n rising until the first edge with req!=0.

Verification
REQ-027 Single requester: req=4'b0100, din2=32'hFFFF0000 held 3 cycles after grant -> gnt=4'b0100, sel=2, dout=32'hFFFF0000 with dout_valid high 3 cycles, then req=0 -> IDLE, busy=0, ptr=3.
REQ-028 All requesting from reset, MAX_BURST=4, din0..3=FFFFFFFF/00000000/FFFF0000/0000FFFF -> grants in order 0,1,2,3,0, each exactly 4 transfers, no idle cycle between owners.
REQ-029 Wrap: ptr=3 after owner 2 releases, req=4'b1001 -> gnt=4'b1000 first, then 4'b0001.
REQ-030 Uncontended burst: req=4'b0010 for 10 cycles, MAX_BURST=4 -> gnt stays 4'b0010, 10 consecutive dout_valid pulses.
REQ-031 Early release: owner 1 drops req after 2 transfers while req[3]=1 -> gnt switches to 4'b1000 on same edge, dout_valid low one cycle, cnt restarts.
REQ-032 Async reset: rst_n pulled low between edges during a burst -> gnt, dout, dout_valid zero before the next edge; after release req=4'b1111 -> first gnt=4'b0001.
